// File: rtl/velocity_reg_bank.sv
// Bank of N signed (Vx, Vy) velocity pairs with addressed clamped writes,
// per-axis bounce negation and a registered one-cycle-latency readback port.
module velocity_reg_bank #(
  parameter int W      = 5,
  parameter int N      = 4,
  parameter int AW     = 2,
  parameter int VRESET = 1,
  parameter int VMAX   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [W-1:0]  vx_in,
  input  logic signed [W-1:0]  vy_in,
  input  logic                 bounce_en,
  input  logic [AW-1:0]        bounce_addr,
  input  logic                 bounce_x,
  input  logic                 bounce_y,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [W-1:0]  vx_out,
  output logic signed [W-1:0]  vy_out,
  output logic                 rd_valid,
  output logic                 collision
);

  localparam logic signed [W-1:0] VMAX_P  = W'(VMAX);
  localparam logic signed [W-1:0] VMIN_P  = -VMAX_P;
  localparam logic signed [W-1:0] VRST_P  = W'(VRESET);
  localparam logic signed [W-1:0] ZERO_P  = '0;

  logic signed [W-1:0] vx_mem [N];
  logic signed [W-1:0] vy_mem [N];

  logic wr_in_range;
  logic bounce_in_range;
  logic rd_in_range;
  logic wr_go;
  logic bounce_go;
  logic same_target;

  // Addresses past the last object only exist when N is not a power of two.
  if (N == (1 << AW)) begin : g_full_range
    assign wr_in_range     = 1'b1;
    assign bounce_in_range = 1'b1;
    assign rd_in_range     = 1'b1;
  end else begin : g_partial_range
    assign wr_in_range     = (32'(wr_addr) < N);
    assign bounce_in_range = (32'(bounce_addr) < N);
    assign rd_in_range     = (32'(rd_addr) < N);
  end

  assign wr_go       = wr_en && wr_in_range;
  assign bounce_go   = bounce_en && bounce_in_range;
  assign same_target = wr_go && bounce_go && (wr_addr == bounce_addr);

  function automatic logic signed [W-1:0] clamp(input logic signed [W-1:0] v);
    if (v > VMAX_P) begin
      return VMAX_P;
    end
    if (v < VMIN_P) begin
      return VMIN_P;
    end
    return v;
  endfunction

  // Bounce is scheduled before the write so a same-address write overrides it;
  // readback samples the array before either update lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        vx_mem[i] <= VRST_P;
        vy_mem[i] <= VRST_P;
      end
      vx_out    <= ZERO_P;
      vy_out    <= ZERO_P;
      rd_valid  <= 1'b0;
      collision <= 1'b0;
    end else begin
      rd_valid  <= rd_en;
      collision <= same_target;

      if (rd_en) begin
        if (rd_in_range) begin
          vx_out <= vx_mem[rd_addr];
          vy_out <= vy_mem[rd_addr];
        end else begin
          vx_out <= ZERO_P;
          vy_out <= ZERO_P;
        end
      end

      if (bounce_go && !same_target) begin
        if (bounce_x) begin
          vx_mem[bounce_addr] <= -vx_mem[bounce_addr];
        end
        if (bounce_y) begin
          vy_mem[bounce_addr] <= -vy_mem[bounce_addr];
        end
      end

      if (wr_go) begin
        vx_mem[wr_addr] <= clamp(vx_in);
        vy_mem[wr_addr] <= clamp(vy_in);
      end
    end
  end

endmodule
